// File: rtl/uart_tb_frame_driver.sv
// Byte FIFO plus start/8N/stop framer driving uart_rx one bit per s_clk_115k, LSB first.
// Start bit follows the pop edge; writes while full are dropped and flagged; cts_n gates frame starts only.

module uart_tb_frame_driver_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   s_clk_115k,
  input  logic                   s_rsth,
  input  logic                   wr_vld,
  input  logic [WIDTH-1:0]       wr_dat,
  output logic                   wr_rdy,
  output logic                   rd_vld,
  output logic [WIDTH-1:0]       rd_dat,
  input  logic                   rd_rdy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // full/empty come from the registered count, so a pop never frees space for a same-cycle write
  assign wr_rdy = (count != (AW + 1)'(DEPTH));
  assign rd_vld = (count != '0);
  assign push   = wr_vld & wr_rdy;
  assign pop    = rd_rdy & rd_vld;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge s_clk_115k) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge s_clk_115k or posedge s_rsth) begin
    if (s_rsth) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module uart_tb_frame_driver #(
  parameter int DEPTH     = 16,
  parameter int STOP_BITS = 1,
  parameter int GAP_BITS  = 0,
  parameter int CTS_EN    = 1
) (
  input  logic                   s_clk_115k,
  input  logic                   s_rsth,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   cts_n,
  output logic                   uart_rx,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   overflow,
  output logic [15:0]            frames_sent
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] bit_cnt;
  logic [3:0] bit_cnt_nxt;
  logic [7:0] shift_q;
  logic [7:0] shift_nxt;
  logic       uart_rx_nxt;
  logic       pop;
  logic       frame_done;
  logic       cts_ok;
  logic       fifo_wr_rdy;
  logic       fifo_rd_vld;
  logic [7:0] fifo_rd_dat;

  uart_tb_frame_driver_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .s_clk_115k (s_clk_115k),
    .s_rsth     (s_rsth),
    .wr_vld     (wr_en),
    .wr_dat     (wr_data),
    .wr_rdy     (fifo_wr_rdy),
    .rd_vld     (fifo_rd_vld),
    .rd_dat     (fifo_rd_dat),
    .rd_rdy     (pop),
    .count      (count)
  );

  assign full   = ~fifo_wr_rdy;
  assign empty  = ~fifo_rd_vld;
  assign cts_ok = (CTS_EN == 0) || !cts_n;

  // uart_rx_nxt is the line value for the cycle after this edge, so the line is a clean flop
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_q;
    uart_rx_nxt = 1'b1;
    pop         = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_rd_vld && cts_ok) begin
          pop         = 1'b1;
          shift_nxt   = fifo_rd_dat;
          state_nxt   = START;
          uart_rx_nxt = 1'b0;
        end
      end
      START: begin
        state_nxt   = DATA;
        bit_cnt_nxt = '0;
        uart_rx_nxt = shift_q[0];
        shift_nxt   = shift_q >> 1;
      end
      DATA: begin
        if (bit_cnt == 4'd7) begin
          state_nxt   = STOP;
          bit_cnt_nxt = '0;
        end else begin
          bit_cnt_nxt = bit_cnt + 4'd1;
          uart_rx_nxt = shift_q[0];
          shift_nxt   = shift_q >> 1;
        end
      end
      STOP: begin
        if (bit_cnt == 4'(STOP_BITS - 1)) begin
          frame_done  = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = (GAP_BITS > 0) ? GAP : IDLE;
        end else begin
          bit_cnt_nxt = bit_cnt + 4'd1;
        end
      end
      GAP: begin
        if (bit_cnt == 4'(GAP_BITS - 1)) begin
          bit_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          bit_cnt_nxt = bit_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s_clk_115k or posedge s_rsth) begin
    if (s_rsth) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_q     <= '0;
      uart_rx     <= 1'b1;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      frames_sent <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift_q <= shift_nxt;
      uart_rx <= uart_rx_nxt;
      busy    <= (state_nxt != IDLE);
      if (wr_en && full) overflow <= 1'b1;
      if (frame_done) frames_sent <= frames_sent + 16'd1;
    end
  end
endmodule

// File: tb/tb_uart_tb_frame_driver.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based line model.
module tb_uart_tb_frame_driver;
  localparam int DEPTH     = 16;
  localparam int STOP_BITS = 1;
  localparam int GAP_BITS  = 0;
  localparam int CTS_EN    = 1;
  localparam int PITCH     = 10 + STOP_BITS + GAP_BITS;

  logic                   s_clk_115k;
  logic                   s_rsth;
  logic                   wr_en;
  logic [7:0]             wr_data;
  logic                   cts_n;
  logic                   uart_rx;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   busy;
  logic                   overflow;
  logic [15:0]            frames_sent;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic       e_rst = 1'b1;
  logic       e_wr  = 1'b0;
  logic       e_cts = 1'b1;
  logic [7:0] e_dat = 8'h00;

  logic [7:0]  m_fifo[$];
  logic [1:0]  m_line[$];
  logic        m_ovf;
  logic        m_rx;
  logic        m_busy;
  logic [15:0] m_frames;

  logic [7:0] rx_q[$];
  int         start_cyc[$];
  logic       dec_abort = 1'b0;

  uart_tb_frame_driver #(
    .DEPTH     (DEPTH),
    .STOP_BITS (STOP_BITS),
    .GAP_BITS  (GAP_BITS),
    .CTS_EN    (CTS_EN)
  ) dut (
    .s_clk_115k  (s_clk_115k),
    .s_rsth      (s_rsth),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .cts_n       (cts_n),
    .uart_rx     (uart_rx),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .busy        (busy),
    .overflow    (overflow),
    .frames_sent (frames_sent)
  );

  initial s_clk_115k = 1'b0;
  always #5 s_clk_115k = ~s_clk_115k;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic logic [7:0] rx_at(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
  endfunction

  function automatic int start_at(input int i);
    return (i < start_cyc.size()) ? start_cyc[i] : -1;
  endfunction

  initial forever begin
    @(posedge s_clk_115k);
    cyc++;
    e_rst = s_rsth;
    e_wr  = wr_en;
    e_dat = wr_data;
    e_cts = cts_n;
  end

  // Reference: each popped byte becomes a list of line values, one per cycle, ending with the idle cycle
  initial begin
    logic [7:0] b;
    logic [1:0] ent;
    int         n;
    m_ovf = 1'b0; m_rx = 1'b1; m_busy = 1'b0; m_frames = '0;
    forever begin
      @(negedge s_clk_115k);
      if (s_rsth || e_rst) begin
        m_fifo.delete(); m_line.delete();
        m_ovf = 1'b0; m_frames = '0; m_rx = 1'b1; m_busy = 1'b0;
      end else begin
        n = m_fifo.size();
        if (m_line.size() == 0 && n > 0 && (CTS_EN == 0 || !e_cts)) begin
          b = m_fifo.pop_front();
          m_line.push_back(2'b00);
          for (int i = 0; i < 8; i++) m_line.push_back({1'b0, b[i]});
          for (int i = 0; i < STOP_BITS; i++) m_line.push_back(2'b01);
          m_line.push_back(2'b11);
          for (int i = 0; i < GAP_BITS; i++) m_line.push_back(2'b01);
        end
        if (e_wr) begin
          if (n == DEPTH) m_ovf = 1'b1;
          else m_fifo.push_back(e_dat);
        end
        if (m_line.size() > 0) begin
          ent  = m_line.pop_front();
          m_rx = ent[0];
          if (ent[1]) m_frames++;
        end else begin
          m_rx = 1'b1;
        end
        m_busy = (m_line.size() > 0);
      end
      chk("rx",     uart_rx,     m_rx);
      chk("count",  count,       m_fifo.size());
      chk("full",   full,        m_fifo.size() == DEPTH);
      chk("empty",  empty,       m_fifo.size() == 0);
      chk("busy",   busy,        m_busy);
      chk("ovf",    overflow,    m_ovf);
      chk("frames", frames_sent, m_frames);
    end
  end

  initial forever begin
    @(posedge s_rsth);
    dec_abort = 1'b1;
  end

  // Line decoder: collects bytes and start-bit cycle numbers independently of the model
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge s_clk_115k);
      if (!s_rsth && uart_rx === 1'b0) begin
        start_cyc.push_back(cyc);
        dec_abort = 1'b0;
        for (int i = 0; i < 8; i++) begin
          @(negedge s_clk_115k);
          b[i] = uart_rx;
        end
        @(negedge s_clk_115k);
        if (!dec_abort) begin
          chk("stop", uart_rx, 1'b1);
          rx_q.push_back(b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge s_clk_115k);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    tick();
    s_rsth = 1'b1;
    tick();
    tick();
    s_rsth = 1'b0;
    rx_q.delete();
    start_cyc.delete();
  endtask

  task automatic wait_start(input int budget, input string tag);
    int i = 0;
    do begin
      @(negedge s_clk_115k);
      i++;
    end while (uart_rx !== 1'b0 && i < budget);
    chk(tag, uart_rx, 1'b0);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i = 0;
    do begin
      @(negedge s_clk_115k);
      i++;
    end while (!(empty === 1'b1 && busy === 1'b0) && i < budget);
    chk(tag, {empty, busy}, 2'b10);
  endtask

  initial begin
    string       msg;
    logic [7:0]  sent[$];
    logic [9:0]  frm;
    logic [7:0]  a;
    logic [7:0]  b;

    s_rsth = 1'b1; wr_en = 1'b0; wr_data = 8'h00; cts_n = 1'b1;
    do_reset();

    @(negedge s_clk_115k);
    chk("rst_rx", uart_rx, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_frames", frames_sent, 0);

    // single 0x45 frame and write-to-start latency
    tick();
    cts_n = 1'b0; wr_data = 8'h45; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    @(negedge s_clk_115k);
    chk("t1_lat_rx", uart_rx, 1'b1);
    chk("t1_lat_cnt", count, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge s_clk_115k);
      frm[i] = uart_rx;
    end
    chk("t1_frame", frm, {1'b1, 8'h45, 1'b0});
    @(negedge s_clk_115k);
    chk("t1_frames", frames_sent, 1);
    chk("t1_busy", busy, 1'b0);

    // 16-byte burst at full pitch
    do_reset();
    cts_n = 1'b0;
    msg = "ECHO ABCDE\nYZ QA";
    for (int i = 0; i < msg.len(); i++) begin
      wr_en = 1'b1; wr_data = msg[i];
      tick();
    end
    wr_en = 1'b0;
    wait_idle(16 * PITCH + 40, "t2_drain");
    chk("t2_nrx", rx_q.size(), 16);
    chk("t2_frames", frames_sent, 16);
    for (int i = 0; i < 16; i++) chk("t2_byte", rx_at(i), msg[i]);
    for (int i = 1; i < 16; i++) chk("t2_pitch", start_at(i) - start_at(i - 1), PITCH);

    // overfill while held off, then release
    do_reset();
    cts_n = 1'b1;
    sent.delete();
    for (int i = 0; i < 17; i++) begin
      a = 8'($urandom);
      wr_en = 1'b1; wr_data = a; sent.push_back(a);
      tick();
    end
    wr_en = 1'b0;
    @(negedge s_clk_115k);
    chk("t3_full", full, 1'b1);
    chk("t3_count", count, 16);
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_rx", uart_rx, 1'b1);
    tick();
    cts_n = 1'b0;
    wait_idle(16 * PITCH + 40, "t3_drain");
    chk("t3_nrx", rx_q.size(), 16);
    for (int i = 0; i < 16; i++) chk("t3_byte", rx_at(i), sent[i]);
    chk("t3_ovf_hold", overflow, 1'b1);

    // cts_n raised mid-frame: frame completes, next held until release
    do_reset();
    cts_n = 1'b1;
    a = 8'($urandom); b = 8'($urandom);
    wr_en = 1'b1; wr_data = a; tick();
    wr_data = b; tick();
    wr_en = 1'b0; cts_n = 1'b0;
    wait_start(8, "t4_start");
    repeat (4) @(negedge s_clk_115k);
    cts_n = 1'b1;
    repeat (20) @(negedge s_clk_115k);
    chk("t4_held_cnt", count, 1);
    chk("t4_held_busy", busy, 1'b0);
    chk("t4_held_rx", uart_rx, 1'b1);
    chk("t4_frames", frames_sent, 1);
    chk("t4_nrx", rx_q.size(), 1);
    chk("t4_byte0", rx_at(0), a);
    tick();
    cts_n = 1'b0;
    @(negedge s_clk_115k);
    chk("t4_pre_rx", uart_rx, 1'b1);
    @(negedge s_clk_115k);
    chk("t4_resume", uart_rx, 1'b0);
    wait_idle(PITCH + 10, "t4_drain");
    chk("t4_nrx2", rx_q.size(), 2);
    chk("t4_byte1", rx_at(1), b);

    // asynchronous reset during data bit 4
    do_reset();
    cts_n = 1'b1;
    wr_en = 1'b1; wr_data = 8'($urandom); tick();
    wr_data = 8'($urandom); tick();
    wr_en = 1'b0; cts_n = 1'b0;
    wait_start(8, "t5_start");
    repeat (5) @(negedge s_clk_115k);
    #2 s_rsth = 1'b1;
    #1;
    chk("t5_rx", uart_rx, 1'b1);
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1'b1);
    chk("t5_frames", frames_sent, 0);
    chk("t5_busy", busy, 1'b0);
    tick();
    tick();
    s_rsth = 1'b0;
    repeat (15) @(negedge s_clk_115k);
    chk("t5_nrx", rx_q.size(), 0);
    chk("t5_idle", uart_rx, 1'b1);

    // push and pop on the same edge with one byte queued
    do_reset();
    cts_n = 1'b1;
    a = 8'($urandom); b = 8'($urandom);
    wr_en = 1'b1; wr_data = a; tick();
    wr_en = 1'b0;
    @(negedge s_clk_115k);
    chk("t6_cnt1", count, 1);
    tick();
    cts_n = 1'b0; wr_en = 1'b1; wr_data = b;
    tick();
    wr_en = 1'b0;
    @(negedge s_clk_115k);
    chk("t6_cnt_same", count, 1);
    chk("t6_start", uart_rx, 1'b0);
    wait_idle(3 * PITCH + 10, "t6_drain");
    chk("t6_nrx", rx_q.size(), 2);
    chk("t6_byte0", rx_at(0), a);
    chk("t6_byte1", rx_at(1), b);

    // random traffic, flow control and occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 19) == 0) cts_n = ~cts_n;
      s_rsth  = ($urandom_range(0, 999) == 0);
      tick();
    end
    s_rsth = 1'b0; wr_en = 1'b0; cts_n = 1'b0;
    wait_idle(DEPTH * PITCH + 40, "rnd_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
